// File: rtl/branch_cdb.sv
// rtl/branch_cdb.sv - branch-ALU result bus receiver with duplicate filter and show-ahead result FIFO
module branch_cdb #(
    parameter int RS_WIDTH   = 3,
    parameter int TAG_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     branchALUSignal,
    input  logic [RS_WIDTH-1:0]      branchALU_CDB_out_RSnum,
    input  logic [TAG_WIDTH-1:0]     branchALU_CDB_out_tag,
    input  logic [DATA_WIDTH-1:0]    branchALU_CDB_out_data,
    input  logic                     flush,
    input  logic                     resultReady,
    output logic                     branchALUFinish,
    output logic [RS_WIDTH-1:0]      branchALU_CDB_RSnum,
    output logic                     resultValid,
    output logic [TAG_WIDTH-1:0]     resultTag,
    output logic [DATA_WIDTH-1:0]    resultData,
    output logic                     resultTaken,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count_nxt;
    logic                  pop;
    logic                  dup;
    logic                  room;
    logic                  push;

    assign resultValid = (count != '0);
    assign pop         = resultValid & resultReady & ~flush;
    // The RS frees the slot at the negedge of the Finish cycle, so only the
    // very next sample of that slot can be a stale repeat.
    assign dup         = branchALUFinish & (branchALU_CDB_out_RSnum == branchALU_CDB_RSnum);
    assign room        = (count < CNT_W'(DEPTH)) | pop;
    assign push        = branchALUSignal & ~dup & room & ~flush;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            count               <= '0;
            branchALUFinish     <= 1'b0;
            branchALU_CDB_RSnum <= '0;
        end else if (flush) begin
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            count               <= '0;
            branchALUFinish     <= 1'b0;
            branchALU_CDB_RSnum <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count               <= count_nxt;
            branchALUFinish     <= push;
            branchALU_CDB_RSnum <= push ? branchALU_CDB_out_RSnum : '0;
        end
    end

    // Contents need no reset: an empty FIFO masks the head to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr]  <= branchALU_CDB_out_tag;
            data_mem[wr_ptr] <= branchALU_CDB_out_data;
        end
    end

    assign resultTag   = resultValid ? tag_mem[rd_ptr]  : '0;
    assign resultData  = resultValid ? data_mem[rd_ptr] : '0;
    assign resultTaken = resultData[0];

endmodule

// File: tb/tb_branch_cdb.sv
// tb/tb_branch_cdb.sv - directed self-checking bench for branch_cdb
module tb_branch_cdb;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig;
    logic [2:0]  rs_in;
    logic [3:0]  tag_in;
    logic [31:0] data_in;
    logic        flush;
    logic        ready;
    logic        finish;
    logic [2:0]  rs_out;
    logic        valid;
    logic [3:0]  tag_out;
    logic [31:0] data_out;
    logic        taken;
    logic [2:0]  count;

    int compared   = 0;
    int mismatched = 0;

    branch_cdb #(.RS_WIDTH(3), .TAG_WIDTH(4), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .branchALUSignal         (sig),
        .branchALU_CDB_out_RSnum (rs_in),
        .branchALU_CDB_out_tag   (tag_in),
        .branchALU_CDB_out_data  (data_in),
        .flush                   (flush),
        .resultReady             (ready),
        .branchALUFinish         (finish),
        .branchALU_CDB_RSnum     (rs_out),
        .resultValid             (valid),
        .resultTag               (tag_out),
        .resultData              (data_out),
        .resultTaken             (taken),
        .count                   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", name, obs, exp, $time);
            $error("check %s", name);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bcast(input logic s, input logic [2:0] r, input logic [3:0] t, input logic [31:0] d);
        sig     = s;
        rs_in   = r;
        tag_in  = t;
        data_in = d;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; ready = 1'b0;
        bcast(1'b0, 3'd0, 4'd0, 32'd0);
        tick(); tick();
        check("rst_count",  32'(count),  32'd0);
        check("rst_valid",  32'(valid),  32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_rsnum",  32'(rs_out), 32'd0);
        check("rst_tag",    32'(tag_out), 32'd0);
        rst = 1'b1;

        // single branch
        ready = 1'b1;
        bcast(1'b1, 3'd2, 4'd5, 32'd1);
        tick();
        check("single_finish", 32'(finish),  32'd1);
        check("single_rsnum",  32'(rs_out),  32'd2);
        check("single_valid",  32'(valid),   32'd1);
        check("single_tag",    32'(tag_out), 32'd5);
        check("single_taken",  32'(taken),   32'd1);
        check("single_count",  32'(count),   32'd1);
        bcast(1'b0, 3'd0, 4'd0, 32'd0);
        tick();
        check("single_finish_drop", 32'(finish),  32'd0);
        check("single_count_end",   32'(count),   32'd0);
        check("single_valid_end",   32'(valid),   32'd0);
        check("single_tag_end",     32'(tag_out), 32'd0);

        // duplicate filter
        ready = 1'b0;
        bcast(1'b1, 3'd3, 4'd7, 32'd0);
        tick();
        check("dup_finish1", 32'(finish), 32'd1);
        check("dup_rsnum1",  32'(rs_out), 32'd3);
        check("dup_count1",  32'(count),  32'd1);
        tick();
        check("dup_finish2", 32'(finish), 32'd0);
        check("dup_count2",  32'(count),  32'd1);
        check("dup_taken",   32'(taken),  32'd0);
        bcast(1'b0, 3'd0, 4'd0, 32'd0);
        ready = 1'b1;
        tick();
        check("dup_drain", 32'(count), 32'd0);

        // full / back-pressure
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bcast(1'b1, 3'(i), 4'(i + 1), 32'(i));
            tick();
        end
        check("full_count",  32'(count),   32'd4);
        check("full_rsnum",  32'(rs_out),  32'd3);
        check("full_head",   32'(tag_out), 32'd1);
        bcast(1'b1, 3'd4, 4'd9, 32'd1);
        tick();
        check("full_refuse_finish", 32'(finish), 32'd0);
        check("full_refuse_rsnum",  32'(rs_out), 32'd0);
        check("full_refuse_count",  32'(count),  32'd4);
        tick();
        check("full_refuse2_finish", 32'(finish), 32'd0);
        ready = 1'b1;
        tick();
        check("full_pp_count",  32'(count),   32'd4);
        check("full_pp_finish", 32'(finish),  32'd1);
        check("full_pp_rsnum",  32'(rs_out),  32'd4);
        check("full_pp_head",   32'(tag_out), 32'd2);
        bcast(1'b0, 3'd0, 4'd0, 32'd0);
        tick();
        check("full_drain_head3", 32'(tag_out), 32'd3);
        tick();
        check("full_drain_head4", 32'(tag_out), 32'd4);
        tick();
        check("full_drain_head9", 32'(tag_out), 32'd9);
        check("full_drain_taken", 32'(taken),   32'd1);
        tick();
        check("full_drain_count", 32'(count), 32'd0);

        // wrap-around streaming
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bcast(1'b1, 3'(i % 8), 4'(i + 1), 32'(i));
            tick();
            check("wrap_tag",   32'(tag_out), 32'(i + 1));
            check("wrap_taken", 32'(taken),   32'(i % 2));
            check("wrap_count", 32'(count),   32'd1);
        end
        bcast(1'b0, 3'd0, 4'd0, 32'd0);
        tick();
        check("wrap_end_count", 32'(count), 32'd0);

        // flush
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bcast(1'b1, 3'(i), 4'(11 + i), 32'd0);
            tick();
        end
        check("flush_pre_count", 32'(count), 32'd3);
        flush = 1'b1;
        bcast(1'b1, 3'd6, 4'd14, 32'd1);
        tick();
        check("flush_count",  32'(count),  32'd0);
        check("flush_finish", 32'(finish), 32'd0);
        check("flush_valid",  32'(valid),  32'd0);
        flush = 1'b0;
        tick();
        check("flush_re_finish", 32'(finish),  32'd1);
        check("flush_re_rsnum",  32'(rs_out),  32'd6);
        check("flush_re_count",  32'(count),   32'd1);
        check("flush_re_tag",    32'(tag_out), 32'd14);
        bcast(1'b0, 3'd0, 4'd0, 32'd0);
        ready = 1'b1;
        tick();
        check("flush_end_count", 32'(count), 32'd0);

        // asynchronous reset mid-stream
        ready = 1'b0;
        bcast(1'b1, 3'd1, 4'd3, 32'd0);
        tick();
        bcast(1'b1, 3'd2, 4'd4, 32'd0);
        tick();
        check("arst_pre_count",  32'(count),  32'd2);
        check("arst_pre_finish", 32'(finish), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_count",  32'(count),   32'd0);
        check("arst_valid",  32'(valid),   32'd0);
        check("arst_finish", 32'(finish),  32'd0);
        check("arst_tag",    32'(tag_out), 32'd0);
        bcast(1'b0, 3'd0, 4'd0, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("arst_post_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_cdb.md
# branch_cdb

Receiving end of the branch-ALU result bus. Samples the branch reservation station's broadcast (`branchALUSignal`, RS number, tag, data), buffers resolved branches in a small FIFO, and returns `branchALUFinish`/`branchALU_CDB_RSnum` so the station frees the entry. The FIFO drains to the ROB/fetcher over a valid/ready handshake. Because the station re-broadcasts a ready entry every cycle until it is freed, this block filters duplicates.

## Interface
- `RS_WIDTH`, 3 — RS-number width (`branchALURSWidth`)
- `TAG_WIDTH`, 4 — tag width (`tagWidth`); tag 0 is `tagFree`
- `DATA_WIDTH`, 32 — result width (`dataWidth`); bit 0 = taken
- `DEPTH`, 4 — FIFO entries, power of two, ≥2
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-low reset
- `branchALUSignal`  in  1  broadcast valid from branch RS
- `branchALU_CDB_out_RSnum`  in  RS_WIDTH  broadcasting RS slot
- `branchALU_CDB_out_tag`  in  TAG_WIDTH  destination tag
- `branchALU_CDB_out_data`  in  DATA_WIDTH  branch result word
- `flush`  in  1  synchronous mispredict flush
- `resultReady`  in  1  consumer accepts head this cycle
- `branchALUFinish`  out  1  registered ack to RS (sampled at RS negedge)
- `branchALU_CDB_RSnum`  out  RS_WIDTH  slot being freed
- `resultValid`  out  1  FIFO non-empty
- `resultTag`  out  TAG_WIDTH  head tag
- `resultData`  out  DATA_WIDTH  head data
- `resultTaken`  out  1  head data bit 0
- `count`  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: DEPTH × {tag, data}; read ptr, write ptr (log2 DEPTH bits, wrap modulo DEPTH), count 0..DEPTH.
- pop = `resultValid & resultReady & ~flush`.
- dup = `branchALUFinish & (branchALU_CDB_out_RSnum == branchALU_CDB_RSnum)`.
- room = `count < DEPTH` or pop.
- push = `branchALUSignal & ~dup & room & ~flush`.
- push: write {tag, data} at write ptr, advance it; next cycle `branchALUFinish`=1, `branchALU_CDB_RSnum` = captured RSnum.
- No push: `branchALUFinish`=0, `branchALU_CDB_RSnum`=0. A broadcast refused for lack of room gets no ack; the RS keeps re-broadcasting, which is the retry mechanism.
- dup broadcasts are dropped silently. The RS clears the slot at the negedge inside the Finish cycle, so only the first following sample can repeat it.
- count' = count + push − pop. Push and pop in the same cycle when full is legal; count stays DEPTH.
- Outputs are show-ahead: `resultTag`/`resultData`/`resultTaken` combinational from the entry at read ptr. When empty, they are 0 (tag 0 = `tagFree`).
- flush: pointers and count go to 0 and Finish deasserts next cycle. Any capture or pop that cycle is discarded.
- Reset (`rst`=0, async): pointers, count, `branchALUFinish`, `branchALU_CDB_RSnum` all 0; `resultValid`=0; result outputs 0. Mid-operation reset discards all contents immediately, without waiting for a clock.

## Timing
- Broadcast visible in cycle n → sampled at posedge n+1 → Finish high in cycle n+1 → RS frees slot at negedge of n+1.
- Re-broadcast of the same slot sampled at posedge n+2 is dropped via dup. A different slot sampled at posedge n+2 is accepted.
- Accept rate: 1 per cycle max; throughput is 1/cycle when consumer is always ready.
- Capture to `resultValid` latency: 1 cycle (visible right after posedge n+1 when empty).
- Finish is a single-cycle pulse per accepted broadcast. It never asserts for dropped or refused broadcasts.

## Test plan
- Reset: hold `rst`=0 mid-stream with 2 entries queued → `count`=0, `resultValid`=0, `branchALUFinish`=0 asynchronously, before the next posedge.
- Single branch: RSnum=2, tag=5, data=1 for one cycle, resultReady=1 → Finish=1 with RSnum=2 for one cycle; `resultTag`=5, `resultTaken`=1 for one cycle; count back to 0.
- Duplicate filter: RSnum=3 held for 2 consecutive cycles (RS retry model) → exactly one push, one Finish pulse, count=1.
- Full/back-pressure: resultReady=0, push RSnums 0..3 → count=4. Broadcast RSnum=4 → no Finish, count stays 4. Raise resultReady for 1 cycle while RSnum=4 broadcasts → push and pop together, count=4, Finish RSnum=4.
- Wrap-around: stream 10 distinct broadcasts (tags 1..10) with resultReady=1 → outputs in order 1..10, no loss, pointers wrap at 4.
- Flush: 3 queued, flush=1 coincident with a broadcast RSnum=6 → count=0 next cycle, no Finish for 6. RSnum=6 rebroadcast afterward → accepted normally.
